// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand-entry stage: target-select encodings,
// key count and the nibble step helper used by the apply logic.
package operand_entry_pkg;

  localparam int NKEYS = 8;

  typedef enum logic [1:0] {
    SEL_N1_LO = 2'b00,
    SEL_N2    = 2'b01,
    SEL_N1_HI = 2'b10,
    SEL_NONE  = 2'b11
  } sel_e;

  // Nibble +/-1 with natural 4-bit wrap (F+1 -> 0, 0-1 -> F), no carry out.
  function automatic logic [3:0] nib_step(input logic [3:0] nib, input logic down);
    return down ? (nib - 4'd1) : (nib + 4'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, debounce FSM on a stable level, and a
// single-cycle registered press pulse on each accepted 0->1 transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  // Counter value at which the next mismatching cycle completes the interval.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stb;
  logic [CNT_W-1:0] cnt;
  logic             stb_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rise;

  // State register: synchronizer flops, stable level, counter and press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stb     <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      stb     <= stb_nxt;
      cnt     <= cnt_nxt;
      press   <= rise;
    end
  end

  // Next state: count consecutive disagreeing cycles, toggle once the run is long enough.
  always_comb begin
    stb_nxt = stb;
    cnt_nxt = '0;
    if (sync_p1 != stb) begin
      if (cnt == CNT_LAST) begin
        stb_nxt = ~stb;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Output decode: only the rising toggle of the stable level counts as a press.
  always_comb begin
    rise = stb_nxt & ~stb;
  end

endmodule

// File: rtl/operand_entry.sv
// Operand-entry stage: debounces eight nibble keys on the system clock and
// steps the addressed nibble of num1 (64 bit) or num2 (32 bit) up or down.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_in,
  input  logic [1:0]       sel,
  input  logic             dec,
  input  logic             clr,
  output logic [63:0]      num1,
  output logic [31:0]      num2,
  output logic             upd,
  output logic [NKEYS-1:0] upd_mask
);

  logic [NKEYS-1:0] press;
  logic [63:0]      num1_nxt;
  logic [31:0]      num2_nxt;
  logic [NKEYS-1:0] mask_nxt;
  sel_e             tgt;

  assign tgt = sel_e'(sel);

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk  (clk),
      .rst  (rst),
      .key  (key_in[i]),
      .press(press[i])
    );
  end

  // Apply every pending press to its own nibble of the selected target.
  always_comb begin
    num1_nxt = num1;
    num2_nxt = num2;
    mask_nxt = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (press[i]) begin
        case (tgt)
          SEL_N1_LO: begin
            num1_nxt[4*i +: 4] = nib_step(num1[4*i +: 4], dec);
            mask_nxt[i]        = 1'b1;
          end
          SEL_N1_HI: begin
            num1_nxt[32+4*i +: 4] = nib_step(num1[32+4*i +: 4], dec);
            mask_nxt[i]           = 1'b1;
          end
          SEL_N2: begin
            num2_nxt[4*i +: 4] = nib_step(num2[4*i +: 4], dec);
            mask_nxt[i]        = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Operand and update-flag registers; clear wins over any same-cycle press.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      num1     <= '0;
      num2     <= '0;
      upd      <= 1'b0;
      upd_mask <= '0;
    end else begin
      num1     <= num1_nxt;
      num2     <= num2_nxt;
      upd      <= |mask_nxt;
      upd_mask <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_operand_entry.sv
// Randomized and directed bench for operand_entry with a queue-based
// reference model and a scoreboard monitor on the update pulse.
module tb_operand_entry;

  localparam int D  = 4;
  localparam int NK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  key_in;
  logic [1:0]  sel;
  logic        dec;
  logic        clr;
  logic [63:0] num1;
  logic [31:0] num2;
  logic        upd;
  logic [7:0]  upd_mask;

  always #5 clk = ~clk;

  operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_in  (key_in),
    .sel     (sel),
    .dec     (dec),
    .clr     (clr),
    .num1    (num1),
    .num2    (num2),
    .upd     (upd),
    .upd_mask(upd_mask)
  );

  typedef struct {
    bit [63:0] n1;
    bit [31:0] n2;
    bit [7:0]  mask;
  } exp_t;

  exp_t      expq[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  bit        checking = 0;

  // Reference model state
  bit [63:0] m_num1;
  bit [31:0] m_num2;
  bit [7:0]  m_d1, m_d2;
  bit        m_stb[NK];
  bit        m_press[NK];
  bit        hist[NK][$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: evaluated on each rising edge with the inputs present there.
  always @(posedge clk) begin
    bit [7:0] mask;
    int       nib;
    int       sh;
    bit       y;
    bit       all_diff;
    if (rst) begin
      m_num1 = 0;
      m_num2 = 0;
      m_d1   = 0;
      m_d2   = 0;
      for (int i = 0; i < NK; i++) begin
        m_stb[i]   = 0;
        m_press[i] = 0;
        hist[i].delete();
      end
      expq.delete();
      checking = 1;
    end else begin
      mask = 0;
      if (clr) begin
        m_num1 = 0;
        m_num2 = 0;
      end else if (sel != 2'b11) begin
        for (int i = 0; i < NK; i++) begin
          if (m_press[i]) begin
            mask[i] = 1;
            if (sel == 2'b01) begin
              sh  = 4 * i;
              nib = int'((m_num2 >> sh) & 32'hF);
              nib = (nib + (dec ? 15 : 1)) % 16;
              m_num2 = (m_num2 & ~(32'hF << sh)) | (32'(nib) << sh);
            end else begin
              sh  = (sel == 2'b10) ? 32 + 4 * i : 4 * i;
              nib = int'((m_num1 >> sh) & 64'hF);
              nib = (nib + (dec ? 15 : 1)) % 16;
              m_num1 = (m_num1 & ~(64'hF << sh)) | (64'(nib) << sh);
            end
          end
        end
      end
      if (mask != 0) expq.push_back('{n1: m_num1, n2: m_num2, mask: mask});
      // Key acceptance: the last D synchronized samples all disagree with the stable level.
      for (int i = 0; i < NK; i++) begin
        y = m_d2[i];
        m_press[i] = 0;
        hist[i].push_back(y);
        if (hist[i].size() > D) void'(hist[i].pop_front());
        if (hist[i].size() == D) begin
          all_diff = 1;
          foreach (hist[i][j]) if (hist[i][j] == m_stb[i]) all_diff = 0;
          if (all_diff) begin
            m_stb[i]   = ~m_stb[i];
            m_press[i] = m_stb[i];
            hist[i].delete();
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = key_in;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (checking) begin
      chk("num1", num1, m_num1);
      chk("num2", {32'h0, num2}, {32'h0, m_num2});
      n_checks++;
      if (upd === 1'b1) begin
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_upd: got upd=1 mask=%h expected no update (t=%0t)", upd_mask, $time);
        end else begin
          e = expq.pop_front();
          chk("upd_mask", {56'h0, upd_mask}, {56'h0, e.mask});
        end
      end else begin
        if (expq.size() != 0) begin
          e = expq.pop_front();
          n_fail++;
          $display("FAIL missed_upd: got upd=%b expected upd=1 mask=%h (t=%0t)", upd, e.mask, $time);
        end
        chk("idle_mask", {56'h0, upd_mask}, 64'h0);
      end
    end
  end

  task automatic press_keys(input bit [7:0] keys, input int hi, input int lo);
    key_in = keys;
    repeat (hi) @(negedge clk);
    key_in = 8'h00;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst = 1; key_in = 0; sel = 2'b00; dec = 0; clr = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_num1", num1, 64'h0);
    chk("reset_upd", {63'h0, upd}, 64'h0);

    // Single increment on nibble 0 of num1; held key gives one update only
    sel = 2'b00; dec = 0;
    press_keys(8'h01, 14, 8);
    chk("inc_key0", num1, 64'h1);

    // Short bounces on key 3 never register
    for (int c = 0; c < 20; c++) begin
      key_in[3] = (c / 2) % 2 == 0;
      @(negedge clk);
    end
    key_in = 0;
    repeat (10) @(negedge clk);
    chk("bounce_key3", num1, 64'h1);

    // Decrement top nibble of num1 twice
    clr = 1; @(negedge clk); clr = 0;
    sel = 2'b10; dec = 1;
    press_keys(8'h80, 8, 8);
    chk("dec_hi_1", num1, 64'hF000_0000_0000_0000);
    press_keys(8'h80, 8, 8);
    chk("dec_hi_2", num1, 64'hE000_0000_0000_0000);

    // Simultaneous keys 1 and 2 on num2, then no-target press
    clr = 1; @(negedge clk); clr = 0;
    sel = 2'b01; dec = 0;
    press_keys(8'h06, 8, 8);
    chk("dual_num2", {32'h0, num2}, 64'h110);
    sel = 2'b11;
    press_keys(8'h02, 8, 8);
    chk("sel_none", {32'h0, num2}, 64'h110);

    // Nibble wrap without carry
    clr = 1; @(negedge clk); clr = 0;
    sel = 2'b01; dec = 1;
    press_keys(8'h01, 8, 8);
    chk("wrap_down", {32'h0, num2}, 64'hF);
    dec = 0;
    press_keys(8'h01, 8, 8);
    chk("wrap_up", {32'h0, num2}, 64'h0);

    // Press landing in the clear cycle is lost
    sel = 2'b00; dec = 0;
    press_keys(8'h01, 8, 8);
    key_in = 8'h01;
    repeat (6) @(posedge clk);
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
    repeat (4) @(negedge clk);
    key_in = 0;
    repeat (8) @(negedge clk);
    chk("clr_prio_n1", num1, 64'h0);

    // Reset mid-debounce with key held through release
    key_in = 8'h01;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    repeat (20) @(negedge clk);
    key_in = 0;
    repeat (8) @(negedge clk);
    chk("rst_mid", num1, 64'h1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 7) == 0) key_in[i] = ~key_in[i];
      sel = 2'($urandom_range(0, 3));
      dec = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    key_in = 0; clr = 0; rst = 0;
    repeat (20) @(negedge clk);
    chk("drain_queue", 64'(expq.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Synchronous operand-entry stage that sits directly upstream of the calculator datapath and the operand display. Takes eight raw nibble keys, a target select and an up/down control, debounces and edge-detects every key on the single system clock, and increments or decrements the selected 4-bit nibble of the 64-bit first operand or the 32-bit second operand. It replaces per-key edge-clocked operand registers with one clock domain and a defined reset.

## Interface
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable clock cycles required to accept a key level change; legal range 1 to 2^24−1.
- CNT_W, default 24: width of each debounce counter, at least clog2(DEBOUNCE_CYCLES+1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  8  raw, asynchronous, bouncing nibble keys; bit i addresses nibble i.
- sel  in  2  target: 00 num1[31:0], 10 num1[63:32], 01 num2[31:0], 11 no target.
- dec  in  1  1 = decrement the nibble by 1, 0 = increment it by 1.
- clr  in  1  synchronous clear of both operands.
- num1  out  64  first operand; reset value 0.
- num2  out  32  second operand; reset value 0.
- upd  out  1  one-cycle pulse when any nibble changed this cycle; reset value 0.
- upd_mask  out  8  nibble indices changed with upd; 0 when upd is 0; reset value 0.

## Operation
- Per key: 2-flop synchronizer, then a debounce FSM with a stable level `stb` (reset 0) and counter `cnt` (reset 0).
- Each cycle where sync ≠ stb, cnt increments; any cycle where sync = stb, cnt clears to 0.
- When cnt reaches DEBOUNCE_CYCLES, stb toggles and cnt clears.
- A 0→1 toggle of stb raises the registered press[i] for exactly one cycle. A 1→0 toggle does nothing.
- Press apply, per key i with press[i]=1, using the sel and dec values of that same cycle:
  - Target nibble = (target base) + 4·i, computed as nibble ± 1 modulo 16. F+1 wraps to 0; 0−1 wraps to F.
  - sel=11: no change, and bit i stays clear in upd_mask.
- Simultaneous presses on several keys each update their own nibble in the same cycle; upd_mask carries every updated bit.
- clr=1: num1 and num2 go to 0, and upd/upd_mask stay 0 that cycle. clr has priority over any press in the same cycle, and that press is lost. The debounce state is unaffected.
- rst=1 clears synchronizers, stb, cnt, press, operands, upd and upd_mask.
  - Reset mid-debounce discards partial counts.
  - A key held through reset release is accepted as a new press after the full debounce interval.
- Bounces shorter than DEBOUNCE_CYCLES never change stb. A held key produces exactly one update; there is no auto-repeat.

## Timing
- Key i first sampled high at edge k and held high from then on:
  - sync output high after edge k+1.
  - stb rises at edge k+1+DEBOUNCE_CYCLES.
  - press[i] is high during the following cycle.
  - num1/num2 and upd change at edge k+2+DEBOUNCE_CYCLES.
- Release needs DEBOUNCE_CYCLES stable low cycles before the next press can be recognised.
- Outputs are registered. num1/num2 hold their value between updates. There is no combinational path from any input to any output.

## Structure
- Package operand_entry_pkg holds:
  - the sel encodings: SEL_N1_LO=2'b00, SEL_N2=2'b01, SEL_N1_HI=2'b10, SEL_NONE=2'b11;
  - the nibble count NKEYS=8.
- One sub-module, key_debounce (synchronizer plus debounce FSM plus press pulse), parameterised by DEBOUNCE_CYCLES and CNT_W and instantiated NKEYS times.
- The operand registers and apply logic live in operand_entry.

## Test plan
- DEBOUNCE_CYCLES=4, reset, sel=00, dec=0, key_in[0] high from edge k: num1=0x1 at edge k+6, upd=1 with upd_mask=0x01 for one cycle; num1 unchanged while the key stays held.
- key_in[3] toggling every 2 cycles for 20 cycles then low: num1, num2 and upd never change.
- sel=10, dec=1, press key 7 from num1=0 → num1=0xF000_0000_0000_0000; press again → 0xE000_0000_0000_0000.
- sel=01, key_in[1] and key_in[2] rise on the same edge → num2=0x0000_0110, upd_mask=0x06; then sel=11 with key 1 pressed → no change, upd=0.
- num2 nibble 0 at F, sel=01, dec=0, press key 0 → nibble wraps to 0 with no carry into nibble 1. Press landing in the same cycle as clr=1 → both operands 0, upd=0.
- rst asserted at debounce count 2 of a key press, key held through reset release → update only DEBOUNCE_CYCLES+2 edges after the first post-reset sample, num1=0x1.
